// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and imem.
// master = fetch side (drives req/addr), slave = memory side (drives ack/rdata).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, req/ack imem fetch, IF/ID pipeline register,
// stall freeze with a one-word hold buffer, and redirect with wrong-path squash.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branchbubble,
  input  logic               loaduse_stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  fetch_stage_if.master      imem,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_KILL = 2'd2
  } state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] pend_pc, pend_pc_nx;
  logic [31:0] hold_buf, hold_buf_nx;
  logic        id_valid_nx;
  logic [31:0] id_instr_nx, id_pc_nx, id_pc4_nx;

  logic        stall;
  logic        ack;
  logic        take_redirect;
  logic [31:0] tgt;
  logic [31:0] pc_inc;

  assign stall         = branchbubble | loaduse_stall;
  assign ack           = imem.imem_ack;
  assign take_redirect = redirect & ~stall;
  assign tgt           = redirect_pc & WORD_MASK;
  assign pc_inc        = pc + 32'd4;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC & WORD_MASK;
      pend_pc  <= '0;
      hold_buf <= '0;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
      id_pc4   <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      pend_pc  <= pend_pc_nx;
      hold_buf <= hold_buf_nx;
      id_valid <= id_valid_nx;
      id_instr <= id_instr_nx;
      id_pc    <= id_pc_nx;
      id_pc4   <= id_pc4_nx;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    pend_pc_nx  = pend_pc;
    hold_buf_nx = hold_buf;
    id_valid_nx = id_valid;
    id_instr_nx = id_instr;
    id_pc_nx    = id_pc;
    id_pc4_nx   = id_pc4;

    unique case (state)
      S_REQ: begin
        if (ack) begin
          if (stall) begin
            // Word arrived while ID is frozen: park it so it is neither lost nor refetched.
            hold_buf_nx = imem.imem_rdata;
            state_nx    = S_HOLD;
          end else if (redirect) begin
            pc_nx       = tgt;
            id_valid_nx = 1'b0;
          end else begin
            id_valid_nx = 1'b1;
            id_instr_nx = imem.imem_rdata;
            id_pc_nx    = pc;
            id_pc4_nx   = pc_inc;
            pc_nx       = pc_inc;
          end
        end else if (!stall) begin
          id_valid_nx = 1'b0;
          if (redirect) begin
            pend_pc_nx = tgt;
            state_nx   = S_KILL;
          end
        end
      end

      S_HOLD: begin
        if (take_redirect) begin
          pc_nx       = tgt;
          id_valid_nx = 1'b0;
          state_nx    = S_REQ;
        end else if (!stall) begin
          id_valid_nx = 1'b1;
          id_instr_nx = hold_buf;
          id_pc_nx    = pc;
          id_pc4_nx   = pc_inc;
          pc_nx       = pc_inc;
          state_nx    = S_REQ;
        end
      end

      S_KILL: begin
        if (!stall) begin
          id_valid_nx = 1'b0;
        end
        if (take_redirect) begin
          pend_pc_nx = tgt;
        end
        // A redirect coinciding with the ack is the latest target and overrides pend_pc.
        if (ack) begin
          pc_nx    = take_redirect ? tgt : pend_pc;
          state_nx = S_REQ;
        end
      end

      default: begin
        state_nx = S_REQ;
      end
    endcase
  end

  // Memory port outputs; S_KILL keeps the old pc on the bus until the ack.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    if (!rst && state != S_HOLD) begin
      imem.imem_req = 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural imem with programmable wait states,
// hand-computed IF/ID expectations (instr = addr ^ 32'hDEAD_0000).
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        branchbubble;
  logic        loaduse_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  int unsigned lat;
  int unsigned wait_cnt;
  int unsigned n_checks;
  int unsigned n_fail;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk           (clk),
    .rst           (rst),
    .branchbubble  (branchbubble),
    .loaduse_stall (loaduse_stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem          (imem),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc4        (id_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: ack after lat wait cycles of a held request (lat=0 is zero-wait).
  assign imem.imem_ack   = imem.imem_req && (wait_cnt >= lat);
  assign imem.imem_rdata = imem.imem_addr ^ 32'hDEAD_0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             wait_cnt <= 0;
    else if (imem.imem_req && imem.imem_ack) wait_cnt <= 0;
    else if (imem.imem_req)              wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; branchbubble = 1'b0; loaduse_stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0; lat = 0;
    tick(); tick();

    // Reset state
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_pc",    id_pc,    32'h0);
    check("rst_pc4",   id_pc4,   32'h0);
    check("rst_req",   32'(imem.imem_req), 32'd0);
    rst = 1'b0;
    #1;
    check("first_req",  32'(imem.imem_req), 32'd1);
    check("first_addr", imem.imem_addr, 32'h3000);

    // Zero-wait streaming
    tick();
    check("s0_valid", 32'(id_valid), 32'd1);
    check("s0_pc",    id_pc,    32'h3000);
    check("s0_instr", id_instr, 32'hDEAD_3000);
    check("s0_pc4",   id_pc4,   32'h3004);
    tick(); check("s1_pc", id_pc, 32'h3004);
    tick(); check("s2_pc", id_pc, 32'h3008);

    // branchbubble for two cycles with ack in the first
    branchbubble = 1'b1;
    tick();
    check("bb0_pc",  id_pc, 32'h3008);
    check("bb0_req", 32'(imem.imem_req), 32'd0);
    tick();
    check("bb1_pc",    id_pc,    32'h3008);
    check("bb1_instr", id_instr, 32'hDEAD_3008);
    branchbubble = 1'b0;
    tick();
    check("bbr_valid", 32'(id_valid), 32'd1);
    check("bbr_pc",    id_pc,    32'h300C);
    check("bbr_instr", id_instr, 32'hDEAD_300C);
    tick();
    check("bbr_next_pc", id_pc, 32'h3010);

    // Zero-wait redirect: one bubble
    redirect = 1'b1; redirect_pc = 32'h3100;
    tick();
    check("rd_bubble", 32'(id_valid), 32'd0);
    check("rd_keep_pc", id_pc, 32'h3010);
    redirect = 1'b0;
    tick();
    check("rd_valid", 32'(id_valid), 32'd1);
    check("rd_pc",    id_pc,  32'h3100);
    check("rd_pc4",   id_pc4, 32'h3104);

    // 3-wait memory, redirect one cycle into the request
    lat = 3;
    tick();
    check("lat_bubble", 32'(id_valid), 32'd0);
    check("lat_addr0",  imem.imem_addr, 32'h3104);
    redirect = 1'b1; redirect_pc = 32'h3200;
    tick();
    check("kill_addr1", imem.imem_addr, 32'h3104);
    check("kill_req1",  32'(imem.imem_req), 32'd1);
    redirect = 1'b0;
    tick();
    check("kill_addr2", imem.imem_addr, 32'h3104);
    check("kill_valid2", 32'(id_valid), 32'd0);
    tick();
    check("kill_newaddr", imem.imem_addr, 32'h3200);
    check("kill_valid3",  32'(id_valid), 32'd0);
    check("kill_keep_pc", id_pc, 32'h3100);
    lat = 0;
    tick();
    check("kill_deliv_valid", 32'(id_valid), 32'd1);
    check("kill_deliv_pc",    id_pc, 32'h3200);

    // Redirect during loaduse_stall is ignored
    loaduse_stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3300;
    tick();
    check("lu0_valid", 32'(id_valid), 32'd1);
    check("lu0_pc",    id_pc, 32'h3200);
    check("lu0_req",   32'(imem.imem_req), 32'd0);
    tick();
    check("lu1_pc",    id_pc,    32'h3200);
    check("lu1_instr", id_instr, 32'hDEAD_3200);
    loaduse_stall = 1'b0; redirect_pc = 32'h3301;
    tick();
    check("lur_bubble", 32'(id_valid), 32'd0);
    check("lur_addr",   imem.imem_addr, 32'h3300);
    redirect = 1'b0;
    tick();
    check("lur_valid", 32'(id_valid), 32'd1);
    check("lur_pc",    id_pc,  32'h3300);
    check("lur_pc4",   id_pc4, 32'h3304);

    // Reset pulsed while in S_KILL
    lat = 3;
    redirect = 1'b1; redirect_pc = 32'h3400;
    tick();
    check("pk_addr", imem.imem_addr, 32'h3304);
    redirect = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 32'(id_valid), 32'd0);
    check("ar_pc",    id_pc,    32'h0);
    check("ar_instr", id_instr, 32'h0);
    check("ar_pc4",   id_pc4,   32'h0);
    check("ar_req",   32'(imem.imem_req), 32'd0);
    tick();
    lat = 0;
    rst = 1'b0;
    #1;
    check("ar_restart_addr", imem.imem_addr, 32'h3000);
    check("ar_restart_req",  32'(imem.imem_req), 32'd1);
    tick();
    check("ar_deliv_pc", id_pc, 32'h3000);

    // PC wrap at 32'hFFFF_FFFC
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    check("wr_bubble", 32'(id_valid), 32'd0);
    check("wr_addr",   imem.imem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    check("wr_pc",    id_pc,    32'hFFFF_FFFC);
    check("wr_pc4",   id_pc4,   32'h0000_0000);
    check("wr_instr", id_instr, 32'h2152_FFFC);
    check("wr_next_addr", imem.imem_addr, 32'h0000_0000);
    tick();
    check("wr_zero_pc",    id_pc,    32'h0000_0000);
    check("wr_zero_instr", id_instr, 32'hDEAD_0000);
    check("wr_zero_pc4",   id_pc4,   32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage with PC register and IF/ID pipeline register, sitting directly upstream of the ID-stage branch hazard logic. Fetches one word per cycle over a req/ack instruction-memory port, freezes on branch-bubble and load-use stalls, and redirects on branches and jumps resolved in ID. Taken redirects squash the wrong-path fetch; the architecture has no delay slot.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- branchbubble  in  1  ID branch/jump operand hazard stall
- loaduse_stall  in  1  ID load-use stall
- redirect  in  1  ID resolved taken branch/jump/jal/jalr
- redirect_pc  in  32  target address; bits [1:0] ignored (forced 0)
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_ack  in  1  request accepted; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- id_valid  out  1  IF/ID holds a real instruction
- id_instr  out  32  IF/ID instruction
- id_pc  out  32  IF/ID instruction address
- id_pc4  out  32  id_pc + 4

## Operation
- stall = branchbubble | loaduse_stall. While stall=1, PC and IF/ID hold and redirect is ignored; ID re-asserts redirect once operands are ready.
- Memory protocol: imem_req, once high, stays high with imem_addr stable until the imem_ack cycle. Ack may arrive in the same cycle as req (zero-wait). imem_req=0 while rst=1.
- State S_REQ (reset state): imem_req=1, imem_addr=pc.
  - ack & redirect & !stall: drop data; pc<=redirect_pc; id_valid<=0; stay.
  - ack & stall: data into hold buffer; go S_HOLD.
  - ack & !stall: IF/ID<={1, rdata, pc, pc+4}; pc<=pc+4; stay.
  - !ack & redirect & !stall: pend_pc<=redirect_pc; id_valid<=0; go S_KILL.
  - !ack & !stall: id_valid<=0 (bubble). !ack & stall: hold everything.
- State S_HOLD: imem_req=0. Buffered word waits for the stall to clear.
  - redirect & !stall: drop buffer; pc<=redirect_pc; id_valid<=0; go S_REQ.
  - !stall: IF/ID<={1, buf, pc, pc+4}; pc<=pc+4; go S_REQ.
  - stall: hold.
- State S_KILL: imem_req=1, imem_addr=old pc, held stable until the in-flight request completes.
  - Another redirect & !stall updates pend_pc; the latest target wins.
  - On ack: drop data; pc<=pend_pc; go S_REQ.
  - id_valid<=0 on every non-stall cycle.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 = 0. pc[1:0] is always 0.
- When id_valid=0, id_instr/id_pc/id_pc4 keep their last values; consumers must qualify with id_valid.

## Timing
- Reset (async assert): pc=RESET_PC, state=S_REQ, pend_pc=0, buffer=0, id_valid=0, id_instr=0, id_pc=0, id_pc4=0. First request goes out in the first cycle after rst deasserts.
- Reset mid-request abandons the transaction; the memory shares rst.
- Zero-wait memory: one instruction per cycle. IF/ID updates on the edge closing the ack cycle.
- Redirect penalty with zero-wait memory: exactly one id_valid=0 cycle, then redirect_pc is in ID.
- N-cycle memory latency: N bubbles per fetch. A redirect during an outstanding request costs the remaining latency plus one full fetch.
- Stall on the same cycle as ack: the word is buffered, not lost or refetched. Release gives back-to-back delivery with no bubble.

## Test plan
- Zero-wait memory, no stalls, RESET_PC=0x3000 -> id_pc = 0x3000, 0x3004, 0x3008 on consecutive cycles, id_valid=1 from cycle 2 after reset release.
- branchbubble high 2 cycles while ack=1 -> id_instr/id_pc frozen 2 cycles; next word enters right after release, no skip, no duplicate.
- redirect=1, redirect_pc=0x3100 with zero-wait ack -> one id_valid=0 cycle, then id_pc=0x3100, id_pc4=0x3104.
- 3-cycle ack latency, redirect to 0x3200 one cycle into the request -> imem_addr stays stable until ack, data dropped, next request to 0x3200, never delivered to ID.
- redirect asserted together with loaduse_stall -> ignored; PC and IF/ID unchanged until a later redirect with stall=0.
- rst pulsed mid-S_KILL, and pc=0xFFFF_FFFC wrap -> all outputs at reset values, fetch restarts at RESET_PC; wrap gives next id_pc=0x0000_0000.
